// File: rtl/reg_wb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_wb_ctrl_pkg
//  Purpose  : Shared constants for the register-bank write-back controller:
//             default address/data widths, grant encoding, zero register.
//  Config   : none (WB_FWD_EN is consumed by reg_wb_ctrl only)
//  Revision : 1.0 - initial release
// ============================================================================
package reg_wb_ctrl_pkg;

    // Default geometry of the register bank: 32 x 16-bit
    localparam int DEF_AW = 5;
    localparam int DEF_DW = 16;

    // Grant encoding: index into the arbiter's valid/grant vectors
    localparam logic GNT_ALU = 1'b0;
    localparam logic GNT_MEM = 1'b1;

    // Hard-wired register (read-only when ZERO_REG_RO is set)
    localparam int REG_ZERO = 0;

endpackage : reg_wb_ctrl_pkg
`default_nettype wire

// File: rtl/wb_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : wb_rr_arb
//  Purpose  : Two-input round-robin arbiter for the bank write port.
//             Bit GNT_ALU is the ALU channel, bit GNT_MEM the load channel.
//             On contention the channel that did not win last time wins.
//  Config   : none
//  Revision : 1.0 - initial release
// ============================================================================
module wb_rr_arb
    import reg_wb_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic       r_last_grant;
    logic [1:0] w_grant;

    // Grant decode; nothing is granted while reset is asserted
    always_comb begin
        w_grant = 2'b00;
        if (!rst_n) begin
            w_grant = 2'b00;
        end else if (valid == 2'b11) begin
            if (r_last_grant == GNT_MEM) begin
                w_grant[GNT_ALU] = 1'b1;
            end else begin
                w_grant[GNT_MEM] = 1'b1;
            end
        end else begin
            w_grant = valid;
        end
    end

    // Remember the last winner; every grant is an accept since ready == grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GNT_MEM;
        end else if (w_grant[GNT_MEM]) begin
            r_last_grant <= GNT_MEM;
        end else if (w_grant[GNT_ALU]) begin
            r_last_grant <= GNT_ALU;
        end
    end

    assign grant = w_grant;

endmodule : wb_rr_arb
`default_nettype wire

// File: rtl/reg_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reg_wb_ctrl
//  Purpose  : Write-back controller for the register bank. Arbitrates the
//             single bank write port between the ALU and load channels,
//             registers the write, and keeps a pending-write scoreboard that
//             decode uses to stall on RAW hazards.
//  Config   : `define WB_FWD_EN adds fwd_a_hit/fwd_b_hit/fwd_data and drops
//             the in-flight write term from the hazard outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_wb_ctrl
    import reg_wb_ctrl_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int ZERO_REG_RO = 1
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    input  logic          rsv_valid,
    input  logic [AW-1:0] rsv_rd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] rb1,
    output logic          hazard_a,
    output logic          hazard_b,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
`ifdef WB_FWD_EN
    output logic          fwd_a_hit,
    output logic          fwd_b_hit,
    output logic [DW-1:0] fwd_data,
`endif
    output logic          rsv_err
);

    localparam int c_NUM_REGS = 1 << AW;
    localparam bit c_ZERO_RO  = (ZERO_REG_RO != 0);

    logic [1:0]            w_req;
    logic [1:0]            w_grant;
    logic                  w_accept;
    logic [AW-1:0]         w_sel_rd;
    logic [DW-1:0]         w_sel_data;
    logic                  w_issue;
    logic                  w_rsv_set;
    logic [c_NUM_REGS-1:0] w_pending_nxt;
    logic                  w_inflight_a;
    logic                  w_inflight_b;
    logic                  w_zero_a;
    logic                  w_zero_b;

    logic                  r_wr_en;
    logic [AW-1:0]         r_wr_addr;
    logic [DW-1:0]         r_wr_data;
    logic [c_NUM_REGS-1:0] r_pending;
    logic                  r_rsv_err;

    // Request vector ordered to match GNT_ALU (bit 0) and GNT_MEM (bit 1)
    assign w_req = {mem_valid, alu_valid};

    wb_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (w_req),
        .grant (w_grant)
    );

    assign alu_ready  = w_grant[GNT_ALU];
    assign mem_ready  = w_grant[GNT_MEM];
    assign w_accept   = |w_grant;
    assign w_sel_rd   = w_grant[GNT_MEM] ? mem_rd   : alu_rd;
    assign w_sel_data = w_grant[GNT_MEM] ? mem_data : alu_data;

    // A write to a read-only register 0 is consumed but never reaches the bank
    assign w_issue   = w_accept & ~(c_ZERO_RO & (w_sel_rd == AW'(REG_ZERO)));
    assign w_rsv_set = rsv_valid & ~(c_ZERO_RO & (rsv_rd == AW'(REG_ZERO)));

    // Next scoreboard: clear the written register, then set the reserved one
    // so a same-edge reservation wins over the clear
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_issue) begin
            w_pending_nxt[w_sel_rd] = 1'b0;
        end
        if (w_rsv_set) begin
            w_pending_nxt[rsv_rd] = 1'b1;
        end
    end

    // Bank write port register: one-cycle enable, address/data held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_issue;
            if (w_issue) begin
                r_wr_addr <= w_sel_rd;
                r_wr_data <= w_sel_data;
            end
        end
    end

    // Scoreboard and sticky double-reservation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_rsv_err <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_rsv_set && r_pending[rsv_rd]) begin
                r_rsv_err <= 1'b1;
            end
        end
    end

    assign w_inflight_a = r_wr_en & (r_wr_addr == ra1);
    assign w_inflight_b = r_wr_en & (r_wr_addr == rb1);
    assign w_zero_a     = c_ZERO_RO & (ra1 == AW'(REG_ZERO));
    assign w_zero_b     = c_ZERO_RO & (rb1 == AW'(REG_ZERO));

`ifdef WB_FWD_EN
    // Decode takes the in-flight value from the forward path, so only
    // outstanding reservations stall
    assign hazard_a  = ~w_zero_a & r_pending[ra1];
    assign hazard_b  = ~w_zero_b & r_pending[rb1];
    assign fwd_a_hit = w_inflight_a;
    assign fwd_b_hit = w_inflight_b;
    assign fwd_data  = r_wr_data;
`else
    // Without forwarding the bank read is stale during the commit cycle
    assign hazard_a = ~w_zero_a & (r_pending[ra1] | w_inflight_a);
    assign hazard_b = ~w_zero_b & (r_pending[rb1] | w_inflight_b);
`endif

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign rsv_err = r_rsv_err;

endmodule : reg_wb_ctrl
`default_nettype wire

// File: tb/tb_reg_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_wb_ctrl
//  Purpose  : Self-checking bench for reg_wb_ctrl: directed scenarios with
//             literal expectations plus randomized traffic compared every
//             cycle against a behavioural model of the write-back rules.
//  Config   : honours WB_FWD_EN
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_wb_ctrl;

    localparam int AW  = 5;
    localparam int DW  = 16;
    localparam int ZRO = 1;

    logic          clk;
    logic          rst_n;
    logic          alu_valid, mem_valid, rsv_valid;
    logic [AW-1:0] alu_rd, mem_rd, rsv_rd, ra1, rb1;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready, hazard_a, hazard_b, wr_en, rsv_err;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
`ifdef WB_FWD_EN
    logic          fwd_a_hit, fwd_b_hit;
    logic [DW-1:0] fwd_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    reg_wb_ctrl #(.AW(AW), .DW(DW), .ZERO_REG_RO(ZRO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
        .ra1       (ra1),
        .rb1       (rb1),
        .hazard_a  (hazard_a),
        .hazard_b  (hazard_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
`ifdef WB_FWD_EN
        .fwd_a_hit (fwd_a_hit),
        .fwd_b_hit (fwd_b_hit),
        .fwd_data  (fwd_data),
`endif
        .rsv_err   (rsv_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_pend[32];
    bit m_last_mem;      // last accepted channel was the load channel
    bit m_wr_en;
    int m_addr, m_data;
    bit m_known;         // address/data are defined (not after a dropped reg-0 write)
    bit m_err;
    bit m_acc_alu, m_acc_mem;

    // ALU wins unless the load channel also requests and the ALU won last
    function automatic void model_grant(output bit ga, output bit gm);
        if (rst_n !== 1'b1) begin
            ga = 1'b0;
            gm = 1'b0;
        end else begin
            ga = alu_valid && (!mem_valid || m_last_mem);
            gm = mem_valid && !ga;
        end
    endfunction

    function automatic bit exp_haz(input int r);
        bit h;
        h = m_pend[r];
`ifndef WB_FWD_EN
        h = h || (m_wr_en && m_addr == r);
`endif
        if (ZRO != 0 && r == 0) h = 1'b0;
        return h;
    endfunction

    always @(posedge clk or negedge rst_n) begin : p_model
        bit ga, gm, was, nwe, nknown, nerr, nlast;
        bit np[32];
        int rd, dat, naddr, ndata;
        if (rst_n !== 1'b1) begin
            for (int i = 0; i < 32; i++) m_pend[i] <= 1'b0;
            m_last_mem <= 1'b1;
            m_wr_en    <= 1'b0;
            m_addr     <= 0;
            m_data     <= 0;
            m_known    <= 1'b1;
            m_err      <= 1'b0;
            m_acc_alu  <= 1'b0;
            m_acc_mem  <= 1'b0;
        end else begin
            model_grant(ga, gm);
            np = m_pend;
            nwe = 1'b0; nknown = m_known; nerr = m_err; nlast = m_last_mem;
            naddr = m_addr; ndata = m_data;
            was = m_pend[int'(rsv_rd)];
            if (ga || gm) begin
                nlast = gm;
                rd  = ga ? int'(alu_rd)   : int'(mem_rd);
                dat = ga ? int'(alu_data) : int'(mem_data);
                if (ZRO != 0 && rd == 0) begin
                    nknown = 1'b0;
                end else begin
                    nwe = 1'b1; naddr = rd; ndata = dat; nknown = 1'b1;
                    np[rd] = 1'b0;
                end
            end
            if (rsv_valid && !(ZRO != 0 && rsv_rd == 0)) begin
                if (was) nerr = 1'b1;
                np[int'(rsv_rd)] = 1'b1;
            end
            m_pend     <= np;
            m_last_mem <= nlast;
            m_wr_en    <= nwe;
            m_addr     <= naddr;
            m_data     <= ndata;
            m_known    <= nknown;
            m_err      <= nerr;
            m_acc_alu  <= ga;
            m_acc_mem  <= gm;
        end
    end

    // Every-cycle comparison, half a period away from the active edge
    always @(negedge clk) begin : p_cmp
        bit ga, gm;
        model_grant(ga, gm);
        chk("alu_ready", alu_ready, ga);
        chk("mem_ready", mem_ready, gm);
        chk("wr_en", wr_en, m_wr_en);
        if (m_known) begin
            chk("wr_addr", wr_addr, m_addr);
            chk("wr_data", wr_data, m_data);
        end
        chk("rsv_err", rsv_err, m_err);
        chk("hazard_a", hazard_a, exp_haz(int'(ra1)));
        chk("hazard_b", hazard_b, exp_haz(int'(rb1)));
`ifdef WB_FWD_EN
        chk("fwd_a_hit", fwd_a_hit, m_wr_en && m_addr == int'(ra1));
        chk("fwd_b_hit", fwd_b_hit, m_wr_en && m_addr == int'(rb1));
        if (m_known) chk("fwd_data", fwd_data, m_data);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        rsv_valid = 1'b0; rsv_rd = '0; ra1 = '0; rb1 = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Mostly low registers so reservations, writes and reads collide often
    function automatic logic [AW-1:0] rnd_reg();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rsv_err", rsv_err, 0);

        // Single ALU write: one-cycle enable after the accept edge
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 16'h1234; #1;
        chk("t1_alu_ready", alu_ready, 1);
        tick(); alu_valid = 1'b0; #1;
        chk("t1_wr_en", wr_en, 1);
        chk("t1_wr_addr", wr_addr, 5);
        chk("t1_wr_data", wr_data, 16'h1234);
        tick(); #1;
        chk("t1_wr_en_off", wr_en, 0);

        // Contention from reset: ALU first, then MEM
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 16'h0011;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 16'h0022; #1;
        chk("t2_alu_first", alu_ready, 1);
        chk("t2_mem_wait", mem_ready, 0);
        tick(); alu_valid = 1'b0; #1;
        chk("t2_mem_second", mem_ready, 1);
        chk("t2_addr1", wr_addr, 1);
        tick(); mem_valid = 1'b0; #1;
        chk("t2_addr2", wr_addr, 2);
        chk("t2_wr_en2", wr_en, 1);
        tick(); #1;
        chk("t2_idle", wr_en, 0);

        // Reservation, then hazard through the commit cycle
        do_reset();
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        tick(); rsv_valid = 1'b0; ra1 = 5'd7; #1;
        chk("t3_haz_pend", hazard_a, 1);
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 16'h0077; #1;
        chk("t3_mem_ready", mem_ready, 1);
        tick(); mem_valid = 1'b0; #1;
        chk("t3_wr_en", wr_en, 1);
`ifdef WB_FWD_EN
        chk("t3_haz_inflight", hazard_a, 0);
`else
        chk("t3_haz_inflight", hazard_a, 1);
`endif
        tick(); #1;
        chk("t3_haz_clear", hazard_a, 0);

        // Same-edge set and clear, then double reservation
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 16'h0003;
        rsv_valid = 1'b1; rsv_rd = 5'd3; ra1 = 5'd3;
        tick(); alu_valid = 1'b0; rsv_valid = 1'b0;
        tick(); #1;
        chk("t4_set_wins", hazard_a, 1);
        chk("t4_no_err", rsv_err, 0);
        rsv_valid = 1'b1; rsv_rd = 5'd3;
        tick(); rsv_valid = 1'b0; #1;
        chk("t4_err", rsv_err, 1);
        tick(); #1;
        chk("t4_err_sticky", rsv_err, 1);

        // Register 0 is read-only
        do_reset();
        rsv_valid = 1'b1; rsv_rd = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 16'hFFFF; ra1 = 5'd0; #1;
        chk("t5_alu_ready", alu_ready, 1);
        tick(); alu_valid = 1'b0; rsv_valid = 1'b0; #1;
        chk("t5_no_wr", wr_en, 0);
        chk("t5_no_haz", hazard_a, 0);
        tick(); #1;
        chk("t5_no_wr2", wr_en, 0);
        chk("t5_no_err", rsv_err, 0);

`ifdef WB_FWD_EN
        // Forwarding of the in-flight write
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 16'hBEEF; ra1 = 5'd9;
        tick(); alu_valid = 1'b0; #1;
        chk("t6_fwd_hit", fwd_a_hit, 1);
        chk("t6_fwd_data", fwd_data, 16'hBEEF);
        chk("t6_haz", hazard_a, 0);
`endif

        // Asynchronous reset drops an in-flight write immediately
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 16'h0044;
        tick(); #1;
        chk("t7_wr_en", wr_en, 1);
        rst_n = 1'b0; #1;
        chk("t7_wr_dropped", wr_en, 0);
        chk("t7_ready_low", alu_ready, 0);
        alu_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // Randomized traffic; requesters hold while valid and not accepted
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            if (!(alu_valid && !m_acc_alu)) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rd    = rnd_reg();
                alu_data  = DW'($urandom);
            end
            if (!(mem_valid && !m_acc_mem)) begin
                mem_valid = ($urandom_range(0, 2) != 0);
                mem_rd    = rnd_reg();
                mem_data  = DW'($urandom);
            end
            rsv_valid = ($urandom_range(0, 3) == 0);
            rsv_rd    = rnd_reg();
            ra1       = rnd_reg();
            rb1       = rnd_reg();
        end
        rst_n = 1'b1;
        clear_inputs();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_reg_wb_ctrl
`default_nettype wire
